// File: rtl/aes_blk_fetch.sv
// ---------------------------------------------------------------------------
// aes_blk_fetch
// Block-fetch sequencer feeding the AES counter-mode datapath. On start it
// reads oplen bytes from XRAM starting at opaddr, one byte per handshake,
// packs them into 128-bit blocks (first byte in [127:120]) and presents each
// block on a valid/ready port with a last-block flag. A short final block is
// zero-padded.
//
// Optional feature macro: AES_FETCH_TIMEOUT_EN
//   defined   -> an ack watchdog aborts the operation after TO_CYC cycles in
//                FETCH without an ack (err pulse, back to IDLE, no done).
//   undefined -> no watchdog, err is constant 0, FETCH waits indefinitely.
//
// All outputs are registered and derived from the next-state values so they
// line up with the state register.
// ---------------------------------------------------------------------------
module aes_blk_fetch #(
   parameter int ADDR_W = 16,
   parameter int TO_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] opaddr,
   input  logic [ADDR_W-1:0] oplen,
   output logic              busy,
   output logic [ADDR_W-1:0] xram_addr,
   output logic              xram_stb,
   input  logic              xram_ack,
   input  logic [7:0]        xram_data_in,
   output logic [127:0]      blk_data,
   output logic              blk_valid,
   input  logic              blk_ready,
   output logic              blk_last,
   output logic              done,
   output logic              err
);

   // State encoding
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_FETCH   = 2'd1;
   localparam logic [1:0] ST_PRESENT = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   // Registered state and datapath
   logic [1:0]        state_r;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W-1:0] rem_r;
   logic [3:0]        bidx_r;
   logic [127:0]      data_r;

   // Registered outputs
   logic busy_r;
   logic stb_r;
   logic valid_r;
   logic last_r;
   logic done_r;
   logic err_r;

   // Next-state values
   logic [1:0]        state_s;
   logic [ADDR_W-1:0] addr_s;
   logic [ADDR_W-1:0] rem_s;
   logic [3:0]        bidx_s;
   logic [127:0]      data_s;
   logic              err_s;

   // Qualified handshakes: acks only count while the request is up
   logic ack_s;
   logic hs_s;
   logic timeout_s;

   assign ack_s = stb_r & xram_ack;
   assign hs_s  = valid_r & blk_ready;

`ifdef AES_FETCH_TIMEOUT_EN
   localparam int TO_W = $clog2(TO_CYC + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

   logic [TO_W-1:0] to_cnt_r;

   // Counts consecutive ack-less FETCH cycles; zero on entry and on each ack
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt_r <= '0;
      end else if ((state_r == ST_FETCH) && !ack_s) begin
         to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
      end else begin
         to_cnt_r <= '0;
      end
   end

   // The TO_CYC-th consecutive cycle without an ack ends the operation
   always_comb begin
      timeout_s = 1'b0;
      if ((state_r == ST_FETCH) && !ack_s && (to_cnt_r == TO_LAST)) begin
         timeout_s = 1'b1;
      end else begin
         timeout_s = 1'b0;
      end
   end
`else
   assign timeout_s = 1'b0;
`endif

   // Next-state, address, counters and block assembly
   always_comb begin
      state_s = state_r;
      addr_s  = addr_r;
      rem_s   = rem_r;
      bidx_s  = bidx_r;
      data_s  = data_r;
      err_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               addr_s = opaddr;
               rem_s  = oplen;
               bidx_s = 4'd0;
               data_s = 128'd0;
               if (oplen == {ADDR_W{1'b0}}) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_FETCH;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (ack_s) begin
               // lane 15-bidx: bit offset (15-bidx)*8 == {~bidx,3'b000}
               data_s[{~bidx_r, 3'b000} +: 8] = xram_data_in;
               addr_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
               rem_s  = rem_r - {{(ADDR_W-1){1'b0}}, 1'b1};
               bidx_s = bidx_r + 4'd1;
               if ((bidx_r == 4'd15) || (rem_r == {{(ADDR_W-1){1'b0}}, 1'b1})) begin
                  state_s = ST_PRESENT;
               end else begin
                  state_s = ST_FETCH;
               end
            end else if (timeout_s) begin
               err_s   = 1'b1;
               state_s = ST_IDLE;
            end else begin
               state_s = ST_FETCH;
            end
         end
         ST_PRESENT: begin
            if (hs_s) begin
               if (rem_r != {ADDR_W{1'b0}}) begin
                  data_s  = 128'd0;
                  bidx_s  = 4'd0;
                  state_s = ST_FETCH;
               end else begin
                  state_s = ST_DONE;
               end
            end else begin
               state_s = ST_PRESENT;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs; rst clears everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         addr_r  <= '0;
         rem_r   <= '0;
         bidx_r  <= 4'd0;
         data_r  <= 128'd0;
         busy_r  <= 1'b0;
         stb_r   <= 1'b0;
         valid_r <= 1'b0;
         last_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         addr_r  <= addr_s;
         rem_r   <= rem_s;
         bidx_r  <= bidx_s;
         data_r  <= data_s;
         busy_r  <= (state_s != ST_IDLE);
         stb_r   <= (state_s == ST_FETCH);
         valid_r <= (state_s == ST_PRESENT);
         last_r  <= (state_s == ST_PRESENT) && (rem_s == {ADDR_W{1'b0}});
         done_r  <= (state_s == ST_DONE);
         err_r   <= err_s;
      end
   end

   assign busy      = busy_r;
   assign xram_addr = addr_r;
   assign xram_stb  = stb_r;
   assign blk_data  = data_r;
   assign blk_valid = valid_r;
   assign blk_last  = last_r;
   assign done      = done_r;
   assign err       = err_r;

endmodule

// File: tb/tb_aes_blk_fetch.sv
// ---------------------------------------------------------------------------
// tb_aes_blk_fetch
// Scoreboard bench: each issued operation pushes its expected read addresses,
// blocks and done event (computed from an XRAM byte array) into queues; a
// monitor pops and compares whenever the DUT shows a read ack, a block
// handshake or done. Directed cycle checks cover the documented timing.
// ---------------------------------------------------------------------------
module tb_aes_blk_fetch;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [15:0]  opaddr = 16'd0;
   logic [15:0]  oplen = 16'd0;
   logic         busy;
   logic [15:0]  xram_addr;
   logic         xram_stb;
   logic         xram_ack = 1'b0;
   logic [7:0]   xram_data_in = 8'd0;
   logic [127:0] blk_data;
   logic         blk_valid;
   logic         blk_ready = 1'b0;
   logic         blk_last;
   logic         done;
   logic         err;

   aes_blk_fetch #(.ADDR_W(16), .TO_CYC(255)) dut (
      .clk(clk), .rst(rst), .start(start), .opaddr(opaddr), .oplen(oplen),
      .busy(busy), .xram_addr(xram_addr), .xram_stb(xram_stb),
      .xram_ack(xram_ack), .xram_data_in(xram_data_in),
      .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
      .blk_last(blk_last), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]   mem [0:65535];
   logic [15:0]  exp_addr_q [$];
   logic [127:0] exp_data_q [$];
   bit           exp_last_q [$];
   int           exp_done = 0;
   int           ack_cnt = 0;
   int           ack_mode = 1;    // 0 random, 1 always, 2 never
   int           ready_mode = 1;  // 0 random, 1 always, 2 never

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference model: the bytes of [a, a+l) in order, 16 per block, zero pad
   task automatic model_push(input logic [15:0] a, input logic [15:0] l);
      int nblk;
      logic [127:0] blk;
      logic [15:0] ad;
      for (int i = 0; i < int'(l); i++) begin
         ad = a + 16'(i);
         exp_addr_q.push_back(ad);
      end
      nblk = (int'(l) + 15) / 16;
      for (int b = 0; b < nblk; b++) begin
         blk = 128'd0;
         for (int j = 0; j < 16; j++) begin
            if (b * 16 + j < int'(l)) begin
               ad = a + 16'(b * 16 + j);
               blk[127 - 8 * j -: 8] = mem[ad];
            end
         end
         exp_data_q.push_back(blk);
         exp_last_q.push_back(b == nblk - 1);
      end
      exp_done++;
   endtask

   // XRAM responder and block consumer, driven away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            xram_ack = 1'b0;
         end else begin
            case (ack_mode)
               0: xram_ack = ($urandom_range(0, 9) < 7);
               1: xram_ack = 1'b1;
               default: xram_ack = 1'b0;
            endcase
         end
         xram_data_in = (xram_ack && xram_stb) ? mem[xram_addr] : 8'($urandom);
         case (ready_mode)
            0: blk_ready = ($urandom_range(0, 9) < 7);
            1: blk_ready = 1'b1;
            default: blk_ready = 1'b0;
         endcase
      end
   end

   // Monitor: compares events that will be accepted at the coming edge
   initial begin
      logic [15:0] ea;
      logic [127:0] ed;
      bit el;
      forever begin
         @(negedge clk);
         #3;
         if (!rst) begin
            if (xram_stb && xram_ack) begin
               ack_cnt++;
               if (exp_addr_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL extra_read: got read at %h expected no read", xram_addr);
               end else begin
                  ea = exp_addr_q.pop_front();
                  chk("xram_addr", xram_addr, ea);
               end
            end
            if (blk_valid && blk_ready) begin
               if (exp_data_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL extra_block: got block %h expected none", blk_data);
               end else begin
                  ed = exp_data_q.pop_front();
                  el = exp_last_q.pop_front();
                  chk("blk_data", blk_data, ed);
                  chk("blk_last", blk_last, el);
               end
            end
            if (done) begin
               chk("done_expected", exp_done > 0, 1);
               if (exp_done > 0) exp_done--;
            end
         end
      end
   end

   task automatic issue(input logic [15:0] a, input logic [15:0] l, input bit push);
      @(negedge clk);
      opaddr = a;
      oplen  = l;
      start  = 1'b1;
      if (push) model_push(a, l);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called in cycle 1 after start; n is the cycle in which done is seen
   task automatic wait_done(input int maxc, output int n, output int fv, output bit ss);
      n = 1; fv = -1; ss = 1'b0;
      while (!done && n < maxc) begin
         if (blk_valid && fv < 0) fv = n;
         if (xram_stb) ss = 1'b1;
         @(negedge clk);
         n++;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL done_timeout: got no done expected done within %0d cycles", maxc);
      end
   endtask

   task automatic settle();
      @(negedge clk);
      chk("addr_q_drained", exp_addr_q.size(), 0);
      chk("blk_q_drained", exp_data_q.size(), 0);
      chk("done_drained", exp_done, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_addr"}, xram_addr, 0);
      chk({tag, "_stb"}, xram_stb, 0);
      chk({tag, "_data"}, blk_data, 0);
      chk({tag, "_valid"}, blk_valid, 0);
      chk({tag, "_last"}, blk_last, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   initial begin
      int n, fv, a0, k;
      bit ss, flag;
      logic [15:0] ra, rl;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      // One full block, ack every cycle: valid in 17, done in 18
      ack_mode = 1; ready_mode = 1;
      issue(16'h0100, 16'd16, 1'b1);
      wait_done(200, n, fv, ss);
      chk("t1_done_cycle", n, 18);
      chk("t1_valid_cycle", fv, 17);
      settle();

      // 20 bytes 0x01..0x14 with random acks/ready: exactly 20 reads
      for (int i = 0; i < 20; i++) mem[16'h0200 + 16'(i)] = 8'(i + 1);
      ack_mode = 0; ready_mode = 0;
      a0 = ack_cnt;
      issue(16'h0200, 16'd20, 1'b1);
      wait_done(1000, n, fv, ss);
      settle();
      chk("t2_ack_count", ack_cnt - a0, 20);

      // Address wrap FFFE, FFFF, 0000, 0001
      issue(16'hFFFE, 16'd4, 1'b1);
      wait_done(1000, n, fv, ss);
      settle();

      // Consumer stall in PRESENT with a start pulse that must be ignored
      ack_mode = 1; ready_mode = 2;
      issue(16'h0300, 16'd16, 1'b1);
      k = 0;
      while (!blk_valid && k < 100) begin @(negedge clk); k++; end
      chk("stall_reached", blk_valid, 1);
      for (int c = 0; c < 10; c++) begin
         chk("stall_valid", blk_valid, 1);
         if (exp_data_q.size() > 0) chk("stall_data", blk_data, exp_data_q[0]);
         chk("stall_stb", xram_stb, 0);
         if (c == 3) begin opaddr = 16'h0400; oplen = 16'd5; start = 1'b1; end
         else start = 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      ready_mode = 1;
      k = 0;
      while (!done && k < 100) begin @(negedge clk); k++; end
      chk("stall_done", done, 1);
      settle();

      // oplen = 0: done in cycle 1, no strobe, no block
      issue(16'h1234, 16'd0, 1'b1);
      wait_done(50, n, fv, ss);
      chk("len0_done_cycle", n, 1);
      chk("len0_no_valid", fv, -1);
      chk("len0_no_stb", ss, 0);
      settle();

      // rst mid-FETCH clears everything at that edge
      ack_mode = 0; ready_mode = 0;
      a0 = ack_cnt;
      issue(16'h0500, 16'd40, 1'b1);
      k = 0;
      while (ack_cnt - a0 < 5 && k < 200) begin @(negedge clk); k++; end
      chk("midrst_in_fetch", xram_stb, 1);
      rst = 1'b1; ack_mode = 2;
      exp_addr_q.delete(); exp_data_q.delete(); exp_last_q.delete(); exp_done = 0;
      @(negedge clk);
      chk_all_zero("midrst");
      rst = 1'b0; ack_mode = 1;
      @(negedge clk);
      chk("midrst_idle", busy, 0);

`ifdef AES_FETCH_TIMEOUT_EN
      // Ack withheld: err in cycle 256, IDLE, no done
      ack_mode = 2;
      issue(16'h0600, 16'd8, 1'b0);
      n = 1; flag = 1'b0;
      while (!err && n < 400) begin
         if (done) flag = 1'b1;
         @(negedge clk);
         n++;
      end
      chk("to_err_cycle", n, 256);
      chk("to_busy", busy, 0);
      chk("to_stb", xram_stb, 0);
      chk("to_no_done", flag, 0);
      @(negedge clk);
      chk("to_err_pulse", err, 0);
      ack_mode = 1;
`else
      // Ack withheld: no err, strobe held high
      ack_mode = 2;
      issue(16'h0600, 16'd8, 1'b0);
      flag = 1'b0;
      repeat (300) begin
         if (err) flag = 1'b1;
         @(negedge clk);
      end
      chk("noto_err", flag, 0);
      chk("noto_stb", xram_stb, 1);
      chk("noto_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      ack_mode = 1;
`endif

      // Randomized operations against the model
      ack_mode = 0; ready_mode = 0;
      for (int r = 0; r < 12; r++) begin
         ra = 16'($urandom);
         rl = 16'($urandom_range(0, 60));
         issue(ra, rl, 1'b1);
         wait_done(3000, n, fv, ss);
         settle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/aes_blk_fetch.md
# aes_blk_fetch

Block-fetch sequencer that sits directly upstream of the AES counter-mode datapath in aes_top. On a start command it reads the operation's plaintext from XRAM, one byte per xram handshake, starting at the opaddr register value for oplen bytes. It packs the bytes into 128-bit blocks and hands each block to the AES core over a valid/ready interface, with a last-block flag. A final partial block is zero-padded.

## Interface
- ADDR_W, 16, XRAM address width and oplen width.
- TO_CYC, 255, ack timeout in cycles; used only when AES_FETCH_TIMEOUT_EN is defined.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  one-cycle start command; ignored unless in IDLE.
- opaddr  in  ADDR_W  base XRAM byte address; sampled on accepted start.
- oplen  in  ADDR_W  byte count; sampled on accepted start.
- busy  out  1  high in every state except IDLE.
- xram_addr  out  ADDR_W  current byte address.
- xram_stb  out  1  read request; held with stable xram_addr until acked.
- xram_ack  in  1  byte valid on xram_data_in; meaningful only while xram_stb=1.
- xram_data_in  in  8  read byte.
- blk_data  out  128  packed block; first fetched byte in [127:120].
- blk_valid  out  1  block available.
- blk_ready  in  1  consumer accepts block.
- blk_last  out  1  qualifies blk_valid: this is the final block.
- done  out  1  one-cycle pulse when the operation completes.
- err  out  1  one-cycle timeout pulse; tied 0 without AES_FETCH_TIMEOUT_EN.

## Operation
- States: IDLE, FETCH, PRESENT, DONE.
- IDLE with start=1: latch opaddr into the address counter. Latch oplen into the remaining-byte counter, rem. Clear blk_data and the byte index, bidx (0..15).
  - rem=0: go to DONE.
  - rem≠0: go to FETCH.
- FETCH: xram_stb=1. On xram_ack=1:
  - write the byte into lane 15-bidx of blk_data;
  - increment xram_addr modulo 2^ADDR_W (0xFFFF wraps to 0x0000);
  - decrement rem and increment bidx.
  - If bidx was 15 or rem was 1, go to PRESENT; otherwise stay in FETCH with stb still high. Back-to-back acks therefore deliver one byte per cycle.
- PRESENT: blk_valid=1. blk_last=1 iff rem=0. blk_data is held stable until the handshake.
  - Handshake when blk_valid and blk_ready are both 1.
  - On handshake with rem≠0: clear blk_data and bidx, go to FETCH.
  - On handshake with rem=0: go to DONE.
- Partial last block: unfilled lanes stay 0. No reads are issued past oplen bytes.
- DONE: done=1 for one cycle, then go to IDLE.
- start in any state other than IDLE has no effect.
- xram_ack while xram_stb=0 is ignored.
- Reset values: busy=0, xram_addr=0, xram_stb=0, blk_data=0, blk_valid=0, blk_last=0, done=0, err=0. State is IDLE and all counters are 0.
- rst during an operation: all of the above reset values apply at that edge. In-flight data is discarded. The next operation needs a new start.

## Timing
- Start accepted at edge 0. Then xram_stb=1 and xram_addr=opaddr from cycle 1.
- With acks in cycles 1..16, blk_valid=1 in cycle 17.
- If blk_ready=1 in cycle 17, the next block's xram_stb=1 is in cycle 18. The alternative is done=1 in cycle 18 if that block was last.
- oplen=0: done=1 in cycle 1, IDLE in cycle 2. No stb and no blk_valid.
- Latency from the last byte's ack to blk_valid is 1 cycle. blk_ready is combinationally unused; it is sampled only at the edge.

## Configuration
- AES_FETCH_TIMEOUT_EN, when defined:
  - A cycle counter runs while in FETCH. It clears on every ack and on entry to FETCH.
  - If it reaches TO_CYC without an ack: err=1 for one cycle, xram_stb drops, go to IDLE. done is not pulsed and any partial block is discarded.
- When undefined: no counter is built, err is constant 0, and FETCH waits indefinitely.

## Test plan
- opaddr=0x0100, oplen=16, ack every cycle, blk_ready=1 -> addresses 0x0100..0x010F. One block with bytes in fetch order [127:120] first, blk_last=1 in cycle 17, done in cycle 18.
- oplen=20, bytes 0x01..0x14 -> block 0 is 0x0102..10, blk_last=0. Block 1 is 0x11121314 followed by 96 zero bits, blk_last=1. Exactly 20 acks.
- opaddr=0xFFFE, oplen=4 -> xram_addr sequence is FFFE, FFFF, 0000, 0001.
- blk_ready held 0 for 10 cycles in PRESENT -> blk_valid and blk_data remain stable, and xram_stb stays 0 until the handshake. A start pulsed meanwhile is ignored.
- oplen=0 -> done in cycle 1, no stb. A second run with rst asserted mid-FETCH -> all outputs 0 at the next edge.
- With the macro defined and TO_CYC=255, ack withheld -> err pulse after 255 cycles in FETCH, then IDLE with no done. Without the macro the same stimulus gives err=0 and stb held high.
